// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: CPU writeback has priority, while I/O writes queue in a FIFO
// and drain in free cycles, with a starvation bound that forces an I/O write through.

// Generic synchronous FIFO, storage unreset, pointers/count cleared by async reset.
// Latency: an entry pushed at an edge is visible at the head from the following cycle.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module rf_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Arbitrates CPU writeback and queued I/O writes onto one registered regfile write port.
// Latency: CPU write 1 cycle; I/O write at least 2 cycles after its handshake (no bypass).
// Backpressure: io_req_ready drops when the FIFO is full; cpu_stall when I/O is forced through.
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cpu_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_data,
  output logic                          cpu_stall,
  input  logic                          io_req_valid,
  input  logic [ADDR_WIDTH-1:0]         io_req_addr,
  input  logic [DATA_WIDTH-1:0]         io_req_data,
  output logic                          io_req_ready,
  output logic                          rf_we,
  output logic [ADDR_WIDTH-1:0]         rf_addr,
  output logic [DATA_WIDTH-1:0]         rf_data,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_count,
  output logic [$clog2(STARVE_LIMIT):0] starve_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } io_wr_t;

  io_wr_t push_dat;
  io_wr_t head;
  logic   cpu_vld;
  logic   fifo_vld;
  logic   force_io;
  logic   grant_io;
  logic   grant_cpu;
  logic   io_push;

  // Writes to r0 are architecturally discarded on both sides.
  assign cpu_vld      = cpu_we && (cpu_addr != '0);
  assign fifo_vld     = (io_fifo_count != '0);
  assign io_req_ready = (io_fifo_count < DEPTH_C);
  assign io_push      = io_req_valid && io_req_ready && (io_req_addr != '0);
  assign push_dat     = '{addr: io_req_addr, data: io_req_data};

  assign force_io  = (starve_count == LIMIT_C) && fifo_vld;
  assign grant_io  = force_io || (!cpu_vld && fifo_vld);
  assign grant_cpu = cpu_vld && !force_io;
  assign cpu_stall = force_io && cpu_vld;

  rf_io_fifo #(
    .WIDTH ($bits(io_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_io_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (io_push),
    .push_dat (push_dat),
    .pop      (grant_io),
    .head_dat (head),
    .count    (io_fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (grant_io) begin
      rf_we   <= 1'b1;
      rf_addr <= head.addr;
      rf_data <= head.data;
    end else if (grant_cpu) begin
      rf_we   <= 1'b1;
      rf_addr <= cpu_addr;
      rf_data <= cpu_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // A non-empty FIFO always produces a grant, so "CPU won while I/O waited" is the only increment case.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_count <= '0;
    end else if (fifo_vld && grant_cpu) begin
      if (starve_count != LIMIT_C) starve_count <= starve_count + 1'b1;
    end else begin
      starve_count <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter with a scoreboard of expected regfile writes.
module tb_regfile_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_stall;
  logic          io_req_valid = 1'b0;
  logic [AW-1:0] io_req_addr = '0;
  logic [DW-1:0] io_req_data = '0;
  logic          io_req_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [1:0]    io_fifo_count;
  logic [2:0]    starve_count;

  regfile_write_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
    .io_req_valid(io_req_valid), .io_req_addr(io_req_addr), .io_req_data(io_req_data),
    .io_req_ready(io_req_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .io_fifo_count(io_fifo_count), .starve_count(starve_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  // Scoreboard: every regfile write must match the next expected write in order.
  always @(posedge clock) begin
    #1;
    if (rf_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: write addr=%0d data=%h, none expected", rf_addr, rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_addr !== mon_e.addr || rf_data !== mon_e.data) begin
          fails++;
          $display("FAIL sb_write: got addr=%0d data=%h want addr=%0d data=%h",
                   rf_addr, rf_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    tests++; if (rf_addr !== '0) begin fails++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
    tests++; if (rf_data !== '0) begin fails++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
    tests++; if (io_fifo_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", io_fifo_count); end
    tests++; if (starve_count !== 3'd0) begin fails++; $display("FAIL reset_starve: got %0d want 0", starve_count); end
    tests++; if (io_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", io_req_ready); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write;
    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_data = 32'hDEADBEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpu_stall: got %b want 0", cpu_stall); end
    tick();
    cpu_we = 1'b0;
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL cpu_latency: rf_we got %b want 1", rf_we); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL cpu_idle_we: got %b want 0", rf_we); end
    tests++; if (rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL cpu_hold: got addr=%0d data=%h want 5/deadbeef", rf_addr, rf_data);
    end
  endtask

  task automatic test_io_drain;
    io_req_valid = 1'b1; io_req_addr = 5'd7; io_req_data = 32'h11;
    exp_q.push_back('{addr: 5'd7, data: 32'h11});
    tick();
    tests++; if (io_fifo_count !== 2'd1) begin fails++; $display("FAIL io_count1: got %0d want 1", io_fifo_count); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL io_no_bypass: rf_we got %b want 0", rf_we); end
    io_req_addr = 5'd8; io_req_data = 32'h22;
    exp_q.push_back('{addr: 5'd8, data: 32'h22});
    tick();
    io_req_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_addr !== 5'd7) begin
      fails++; $display("FAIL io_r7_at_push2: got we=%b addr=%0d want 1/7", rf_we, rf_addr);
    end
    tests++; if (io_fifo_count !== 2'd1) begin fails++; $display("FAIL io_pushpop_count: got %0d want 1", io_fifo_count); end
    tick();
    tests++; if (rf_addr !== 5'd8) begin fails++; $display("FAIL io_r8_at_push3: got %0d want 8", rf_addr); end
    tests++; if (io_fifo_count !== 2'd0) begin fails++; $display("FAIL io_count0: got %0d want 0", io_fifo_count); end
    tick();
  endtask

  task automatic test_fifo_full;
    cpu_we = 1'b1; cpu_addr = 5'd10; cpu_data = 32'h1000_000A;
    io_req_valid = 1'b1; io_req_addr = 5'd11; io_req_data = 32'h1000_000B;
    exp_q.push_back('{addr: 5'd10, data: 32'h1000_000A});
    tick();
    cpu_addr = 5'd12; cpu_data = 32'h1000_000C;
    io_req_addr = 5'd13; io_req_data = 32'h1000_000D;
    exp_q.push_back('{addr: 5'd12, data: 32'h1000_000C});
    tick();
    tests++; if (io_fifo_count !== 2'd2) begin fails++; $display("FAIL full_count: got %0d want 2", io_fifo_count); end
    tests++; if (starve_count !== 3'd1) begin fails++; $display("FAIL full_starve: got %0d want 1", starve_count); end
    cpu_we = 1'b0;
    io_req_addr = 5'd14; io_req_data = 32'h1000_000E;
    exp_q.push_back('{addr: 5'd11, data: 32'h1000_000B});
    #1;
    tests++; if (io_req_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", io_req_ready); end
    tick();
    tests++; if (io_fifo_count !== 2'd1) begin fails++; $display("FAIL full_no_push: got %0d want 1", io_fifo_count); end
    tests++; if (io_req_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_pop: got %b want 1", io_req_ready); end
    tests++; if (starve_count !== 3'd0) begin fails++; $display("FAIL full_starve_clr: got %0d want 0", starve_count); end
    exp_q.push_back('{addr: 5'd13, data: 32'h1000_000D});
    tick();
    io_req_valid = 1'b0;
    tests++; if (io_fifo_count !== 2'd1) begin fails++; $display("FAIL full_third_push: got %0d want 1", io_fifo_count); end
    exp_q.push_back('{addr: 5'd14, data: 32'h1000_000E});
    tick();
    tests++; if (io_fifo_count !== 2'd0) begin fails++; $display("FAIL full_drained: got %0d want 0", io_fifo_count); end
    tick();
  endtask

  task automatic test_starve;
    io_req_valid = 1'b1; io_req_addr = 5'd20; io_req_data = 32'hA0A0_0020;
    tick();
    io_req_valid = 1'b0;
    cpu_we = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cpu_addr = AW'(20 + k); cpu_data = 32'hC000_0000 + k;
      exp_q.push_back('{addr: AW'(20 + k), data: 32'hC000_0000 + k});
      #1;
      tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL starve_stall_%0d: got %b want 0", k, cpu_stall); end
      tick();
      tests++; if (starve_count !== 3'(k)) begin fails++; $display("FAIL starve_cnt_%0d: got %0d want %0d", k, starve_count, k); end
    end
    cpu_addr = 5'd25; cpu_data = 32'hC000_0025;
    exp_q.push_back('{addr: 5'd20, data: 32'hA0A0_0020});
    exp_q.push_back('{addr: 5'd25, data: 32'hC000_0025});
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL starve_force_stall: got %b want 1", cpu_stall); end
    tick();
    tests++; if (rf_addr !== 5'd20) begin fails++; $display("FAIL starve_io_first: got addr %0d want 20", rf_addr); end
    tests++; if (starve_count !== 3'd0) begin fails++; $display("FAIL starve_reset: got %0d want 0", starve_count); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL starve_stall_one_cycle: got %b want 0", cpu_stall); end
    tick();
    cpu_we = 1'b0;
    tests++; if (rf_addr !== 5'd25) begin fails++; $display("FAIL starve_held_cpu: got addr %0d want 25", rf_addr); end
    tick();
  endtask

  task automatic test_r0;
    cpu_we = 1'b1; cpu_addr = 5'd0; cpu_data = 32'hFFFF_FFFF;
    io_req_valid = 1'b1; io_req_addr = 5'd0; io_req_data = 32'hEEEE_EEEE;
    #1;
    tests++; if (io_req_ready !== 1'b1) begin fails++; $display("FAIL r0_ready: got %b want 1", io_req_ready); end
    tick();
    cpu_we = 1'b0; io_req_valid = 1'b0;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL r0_cpu_we: got %b want 0", rf_we); end
    tests++; if (io_fifo_count !== 2'd0) begin fails++; $display("FAIL r0_count: got %0d want 0", io_fifo_count); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL r0_io_we: got %b want 0", rf_we); end
  endtask

  task automatic test_reset_mid;
    cpu_we = 1'b1; cpu_addr = 5'd1; cpu_data = 32'hB000_0001;
    io_req_valid = 1'b1; io_req_addr = 5'd3; io_req_data = 32'hB000_0003;
    exp_q.push_back('{addr: 5'd1, data: 32'hB000_0001});
    tick();
    cpu_addr = 5'd2; cpu_data = 32'hB000_0002;
    io_req_addr = 5'd4; io_req_data = 32'hB000_0004;
    exp_q.push_back('{addr: 5'd2, data: 32'hB000_0002});
    tick();
    io_req_valid = 1'b0;
    cpu_addr = 5'd6; cpu_data = 32'hB000_0006;
    exp_q.push_back('{addr: 5'd6, data: 32'hB000_0006});
    tick();
    cpu_addr = 5'd9; cpu_data = 32'hB000_0009;
    exp_q.push_back('{addr: 5'd9, data: 32'hB000_0009});
    tick();
    cpu_we = 1'b0;
    tests++; if (io_fifo_count !== 2'd2 || starve_count !== 3'd3) begin
      fails++; $display("FAIL mid_setup: got count=%0d starve=%0d want 2/3", io_fifo_count, starve_count);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (rf_we !== 1'b0 || rf_addr !== '0 || rf_data !== '0) begin
      fails++; $display("FAIL mid_async_rf: got we=%b addr=%0d data=%h want zeros", rf_we, rf_addr, rf_data);
    end
    tests++; if (io_fifo_count !== 2'd0 || starve_count !== 3'd0) begin
      fails++; $display("FAIL mid_async_cnt: got count=%0d starve=%0d want 0/0", io_fifo_count, starve_count);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (rf_we !== 1'b0 || io_fifo_count !== 2'd0) begin
        fails++; $display("FAIL mid_stale_%0d: got we=%b count=%0d want 0/0", i, rf_we, io_fifo_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_io_drain();
    test_fifo_full();
    test_starve();
    test_r0();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_missing: %0d expected writes never appeared, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: the CPU writeback stage (high priority) and the I/O controller (low priority, buffered).
- The I/O controller pushes sensor and status writes into a small FIFO. These writes are drained whenever the CPU does not use the port.
- A starvation counter bounds the I/O wait. When the bound is reached, the block stalls the CPU for one cycle.
- The block sits between writeback/I-O and the regfile write inputs: rf_we, rf_addr, rf_data.

Parameters:
- ADDR_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 2, number of I/O FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, number of consecutive CPU wins with a pending I/O entry before I/O is forced through.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-low reset.
- cpu_we, in, 1, CPU write request this cycle.
- cpu_addr, in, ADDR_WIDTH, CPU destination register.
- cpu_data, in, DATA_WIDTH, CPU write data.
- cpu_stall, out, 1, combinational; CPU must hold cpu_we/addr/data next cycle.
- io_req_valid, in, 1, I/O write request.
- io_req_addr, in, ADDR_WIDTH, I/O destination register.
- io_req_data, in, DATA_WIDTH, I/O write data.
- io_req_ready, out, 1, FIFO can accept; a transfer occurs on valid&&ready at the clock edge.
- rf_we, out, 1, registered regfile write enable.
- rf_addr, out, ADDR_WIDTH, registered regfile write address.
- rf_data, out, DATA_WIDTH, registered regfile write data.
- io_fifo_count, out, log2(FIFO_DEPTH)+1, current FIFO occupancy.
- starve_count, out, log2(STARVE_LIMIT)+1, current starvation counter.

Behaviour:

Reset:
- reset low (async) clears the following: rf_we=0, rf_addr=0, rf_data=0, FIFO pointers and count=0, starve_count=0.
- With the FIFO empty after reset, io_req_ready=1 and cpu_stall=0.
- Reset mid-operation flushes all pending I/O entries. They are lost, not written.

Register 0:
- A CPU request with cpu_addr==0 is treated as cpu_we=0.
- An I/O request with addr==0 is accepted (handshake completes) but not enqueued.

Grant (combinational, one winner per cycle):
- force = (starve_count==STARVE_LIMIT) && FIFO non-empty.
- If force: I/O head wins. cpu_stall=1, but only if the CPU has a valid request; otherwise cpu_stall=0.
- Else if a valid CPU request exists: CPU wins, cpu_stall=0.
- Else if FIFO non-empty: I/O head wins.
- Else: no grant.

Output:
- The winner's addr/data are registered onto rf_* with rf_we=1 at the next edge, giving one cycle latency.
- With no grant, rf_we=0 and rf_addr/rf_data hold their previous values.

FIFO:
- io_req_ready = (count < FIFO_DEPTH), computed from registered count only. No push when full, even if a pop occurs the same cycle.
- Push and pop in the same cycle leave count unchanged.
- There is no bypass: an entry pushed at edge N is eligible for grant at cycle N+1 at the earliest, and reaches rf_* at edge N+2.
- Pointers wrap modulo FIFO_DEPTH.
- Entries drain in strict FIFO order.

Starvation counter:
- At each edge, if the FIFO is non-empty before the edge and the CPU won: starve_count += 1, saturating at STARVE_LIMIT.
- If the I/O head was granted, or the FIFO is empty: starve_count = 0.

Ordering:
- No address merging or hazard checking between requesters. Writes land in grant order.
- A CPU write and an I/O write to the same register land in that order, and the later one persists.

Test Plan:
- Reset, then CPU write r5=0xDEADBEEF with idle I/O → rf_we=1, rf_addr=5, rf_data=0xDEADBEEF exactly one cycle later; cpu_stall never asserted.
- Push I/O r7=0x11 and r8=0x22 with the CPU idle → rf writes r7 at push+2 and r8 at push+3; io_fifo_count returns to 0.
- FIFO full (2 entries), io_req_valid held → io_req_ready=0; no third entry accepted until the cycle after a pop.
- CPU writes every cycle with one I/O entry pending → four consecutive CPU grants (starve_count 1..4), then cpu_stall=1 for one cycle and the I/O entry is written; the held CPU write lands the following cycle and starve_count=0.
- CPU write to r0 and I/O write to r0 → rf_we stays 0; the I/O handshake completes and io_fifo_count is unchanged.
- Assert reset for 1 cycle with 2 FIFO entries pending and starve_count=3 → all outputs zero immediately (asynchronous), count=0, and no stale write appears after release.
